// File: rtl/stopwatch_ctrl.sv
// Sequencing block for the BCD MM:SS stopwatch: button debounce, run/pause/done FSM,
// speed-selectable count tick and one-cycle load strobes for the counter's loader path.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV   = 16,
    parameter int unsigned DEB_CYCLES = 3
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       btn_start,
    input  logic       btn_reverse,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       btn_clear,
    input  logic       btn_speed_up,
    input  logic       btn_speed_down,
    input  logic       at_limit,
    output logic       tick,
    output logic       run,
    output logic       reverse,
    output logic       load_clear,
    output logic       load_add,
    output logic       load_sub,
    output logic [1:0] speed_lvl,
    output logic [1:0] state
);

    localparam int NumBtn = 7;
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q, sync2_q, deb_q, evt_q;
    logic [DebW-1:0]   deb_cnt_q [NumBtn];

    assign btn_raw = {btn_speed_down, btn_speed_up, btn_clear, btn_sub,
                      btn_add, btn_reverse, btn_start};

    // Event fires once when the stable-high count completes; re-arms only after a low sample.
    always_ff @(posedge clk) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            evt_q   <= '0;
            for (int i = 0; i < NumBtn; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NumBtn; i++) begin
                evt_q[i] <= 1'b0;
                if (!sync2_q[i]) begin
                    deb_cnt_q[i] <= '0;
                    deb_q[i]     <= 1'b0;
                end else if (!deb_q[i]) begin
                    if (deb_cnt_q[i] == DebMax) begin
                        deb_q[i] <= 1'b1;
                        evt_q[i] <= 1'b1;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    logic ev_clear, ev_add, ev_sub, ev_load, ev_start, ev_rev, ev_up, ev_down;

    assign ev_clear = evt_q[4];
    assign ev_add   = evt_q[2] & ~evt_q[3];
    assign ev_sub   = evt_q[3] & ~evt_q[2];
    assign ev_load  = ev_add | ev_sub;
    assign ev_start = evt_q[0] & ~ev_clear & ~ev_load;
    assign ev_rev   = evt_q[1] & ~ev_clear & ~ev_load & ~evt_q[0];
    assign ev_up    = evt_q[5];
    assign ev_down  = evt_q[6];

    state_e          state_q, state_d;
    logic            reverse_q, reverse_d;
    logic [1:0]      speed_q, speed_d;
    logic [PreW-1:0] pre_q, pre_d, div_m1;
    logic            tick_q, tick_d, run_q;
    logic            clr_q, clr_d, add_q, add_d, sub_q, sub_d;

    assign div_m1 = PreW'((TICK_DIV >> speed_q) - 1);

    always_comb begin
        state_d   = state_q;
        reverse_d = reverse_q;
        speed_d   = speed_q;
        pre_d     = pre_q;
        tick_d    = 1'b0;
        clr_d     = 1'b0;
        add_d     = 1'b0;
        sub_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_clear) begin
                    clr_d = 1'b1;
                end else if (ev_load) begin
                    add_d = ev_add;
                    sub_d = ev_sub;
                end else if (ev_start) begin
                    if (!at_limit) state_d = StRun;
                end else if (ev_rev) begin
                    reverse_d = ~reverse_q;
                end
            end
            StRun: begin
                if (ev_clear) begin
                    clr_d   = 1'b1;
                    state_d = StIdle;
                end else if (at_limit) begin
                    state_d = StDone;
                end else if (ev_start) begin
                    state_d = StPause;
                end else if (pre_q == div_m1) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            StPause: begin
                if (ev_clear) begin
                    clr_d   = 1'b1;
                    state_d = StIdle;
                end else if (ev_load) begin
                    add_d = ev_add;
                    sub_d = ev_sub;
                end else if (ev_start) begin
                    state_d = StRun;
                end else if (ev_rev) begin
                    reverse_d = ~reverse_q;
                end
            end
            StDone: begin
                if (ev_clear) begin
                    clr_d   = 1'b1;
                    state_d = StIdle;
                end else if (ev_load) begin
                    add_d   = ev_add;
                    sub_d   = ev_sub;
                    state_d = StPause;
                end else if (ev_rev) begin
                    reverse_d = ~reverse_q;
                    state_d   = StPause;
                end
            end
        endcase
        if (state_d == StIdle || state_d == StDone) pre_d = '0;
        if (ev_up && !ev_down && speed_q != 2'd3) begin
            speed_d = speed_q + 2'd1;
        end else if (ev_down && !ev_up && speed_q != 2'd0) begin
            speed_d = speed_q - 2'd1;
        end
        // A speed change restarts the period, so no tick from the old divisor.
        if (speed_d != speed_q) begin
            pre_d  = '0;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= StIdle;
            reverse_q <= 1'b0;
            speed_q   <= 2'd0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            run_q     <= 1'b0;
            clr_q     <= 1'b0;
            add_q     <= 1'b0;
            sub_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            reverse_q <= reverse_d;
            speed_q   <= speed_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            run_q     <= (state_d == StRun);
            clr_q     <= clr_d;
            add_q     <= add_d;
            sub_q     <= sub_d;
        end
    end

    assign tick       = tick_q;
    assign run        = run_q;
    assign reverse    = reverse_q;
    assign load_clear = clr_q;
    assign load_add   = add_q;
    assign load_sub   = sub_q;
    assign speed_lvl  = speed_q;
    assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a per-cycle reference model pushes expected outputs,
// a monitor pops and compares them after every clock edge.
module tb_stopwatch_ctrl;

    localparam int unsigned TickDiv   = 16;
    localparam int unsigned DebCycles = 3;
    localparam int HistLen = DebCycles + 3;
    localparam int BStart = 0, BRev = 1, BAdd = 2, BSub = 3, BClr = 4, BUp = 5, BDn = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic [6:0] pins = '0;
    logic       al   = 1'b0;
    logic       tick, run, reverse, load_clear, load_add, load_sub;
    logic [1:0] speed_lvl, state;

    stopwatch_ctrl #(
        .TICK_DIV  (TickDiv),
        .DEB_CYCLES(DebCycles)
    ) dut (
        .clk           (clk),
        .RESET         (rst),
        .btn_start     (pins[BStart]),
        .btn_reverse   (pins[BRev]),
        .btn_add       (pins[BAdd]),
        .btn_sub       (pins[BSub]),
        .btn_clear     (pins[BClr]),
        .btn_speed_up  (pins[BUp]),
        .btn_speed_down(pins[BDn]),
        .at_limit      (al),
        .tick          (tick),
        .run           (run),
        .reverse       (reverse),
        .load_clear    (load_clear),
        .load_add      (load_add),
        .load_sub      (load_sub),
        .speed_lvl     (speed_lvl),
        .state         (state)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    // Reference model: states 0 idle, 1 run, 2 pause, 3 done.
    int       m_state = 0, m_speed = 0, m_cnt = 0;
    bit       m_rev = 1'b0;
    bit [6:0] m_evt = '0;
    bit [6:0] m_hist [HistLen];

    task automatic model_step(output logic [9:0] out);
        bit t, lc, la, ls, running, ok;
        bit clr, ad, sb, ld, st, rv, up, dn;
        int old, div, ns;
        t = 0; lc = 0; la = 0; ls = 0; running = 0;
        if (rst) begin
            m_state = 0; m_speed = 0; m_cnt = 0; m_rev = 0; m_evt = '0;
            for (int k = 0; k < HistLen; k++) m_hist[k] = '0;
            out = '0;
            return;
        end
        clr = m_evt[BClr];
        ad  = m_evt[BAdd] && !m_evt[BSub];
        sb  = m_evt[BSub] && !m_evt[BAdd];
        ld  = ad || sb;
        st  = m_evt[BStart];
        rv  = m_evt[BRev];
        up  = m_evt[BUp];
        dn  = m_evt[BDn];
        old = m_state;
        if (clr) begin
            lc = 1; m_state = 0;
        end else if (old == 1) begin
            if (al) m_state = 3;
            else if (st && !ld) m_state = 2;
            else running = 1;
        end else if (ld) begin
            la = ad; ls = sb;
            if (old == 3) m_state = 2;
        end else if (st) begin
            if ((old == 0 && !al) || old == 2) m_state = 1;
        end else if (rv) begin
            m_rev = !m_rev;
            if (old == 3) m_state = 2;
        end
        div = int'(TickDiv >> m_speed);
        if (running) begin
            if (m_cnt == div - 1) begin t = 1; m_cnt = 0; end
            else m_cnt++;
        end else if (m_state == 0 || m_state == 3) begin
            m_cnt = 0;
        end
        ns = m_speed;
        if (up && !dn && ns < 3) ns++;
        else if (dn && !up && ns > 0) ns--;
        if (ns != m_speed) begin m_speed = ns; m_cnt = 0; t = 0; end
        // Event = DebCycles high pin samples (seen two edges late) after a low one.
        for (int k = HistLen - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = pins;
        for (int i = 0; i < 7; i++) begin
            ok = !m_hist[DebCycles+2][i];
            for (int k = 2; k <= int'(DebCycles) + 1; k++) ok = ok & m_hist[k][i];
            m_evt[i] = ok;
        end
        out = {t, (m_state == 1), m_rev, lc, la, ls, 2'(m_speed), 2'(m_state)};
    endtask

    task automatic step(input int n);
        logic [9:0] e;
        repeat (n) begin
            model_step(e);
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [6:0] mask, input int hi, input int lo);
        pins = mask;
        step(hi);
        pins = '0;
        step(lo);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor and measurement bookkeeping.
    int   cyc = 0, last_tick = -1, tick_gap = 0, run_rise = -1, first_gap = 0;
    int   n_tick = 0, n_clr = 0, n_add = 0, n_sub = 0;
    logic prev_run = 1'b0, first_pending = 1'b0;

    initial begin
        logic [9:0] act, e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = {tick, run, reverse, load_clear, load_add, load_sub, speed_lvl, state};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs edge %0d: got %b, expected %b (tick run rev clr add sub spd st)",
                             cyc, act, e);
                end
            end
            if (run && !prev_run) begin
                run_rise = cyc;
                first_pending = 1'b1;
            end
            prev_run = run;
            if (tick) begin
                n_tick++;
                if (last_tick >= 0) tick_gap = cyc - last_tick;
                last_tick = cyc;
                if (first_pending) begin
                    first_gap = cyc - run_rise;
                    first_pending = 1'b0;
                end
            end
            if (load_clear) n_clr++;
            if (load_add) n_add++;
            if (load_sub) n_sub++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int t0, k, a0, c0, b;
        rst = 1'b1; pins = '0; al = 1'b0;
        step(2);
        rst = 1'b0;
        step(50);
        check("idle_state", state, 0);
        check("idle_ticks", n_tick, 0);
        check("idle_strobes", n_clr + n_add + n_sub, 0);

        t0 = cyc + 1;
        press(7'(1 << BStart), 10, 6);
        check("start_edge", run_rise - t0 + 1, 6);
        step(64);
        check("first_tick_l0", first_gap, 16);
        check("tick_period_l0", tick_gap, 16);

        repeat (3) press(7'(1 << BUp), 6, 6);
        step(20);
        check("speed_l3", speed_lvl, 3);
        check("tick_period_l3", tick_gap, 2);
        press(7'(1 << BUp), 6, 6);
        check("speed_sat", speed_lvl, 3);
        repeat (3) press(7'(1 << BStart), 2, 3);
        check("glitch_state", state, 1);

        step(3);
        al = 1'b1;
        k = n_tick;
        step(1);
        check("done_state", state, 3);
        step(5);
        check("done_no_tick", n_tick - k, 0);
        a0 = n_add;
        press(7'(1 << BAdd), 6, 6);
        check("done_add_pulse", n_add - a0, 1);
        check("done_add_state", state, 2);
        al = 1'b0;
        press(7'(1 << BStart), 6, 6);
        check("resume_state", state, 1);
        press(7'(1 << BStart), 6, 6);
        check("pause_state", state, 2);
        a0 = n_add + n_sub;
        press(7'((1 << BAdd) | (1 << BSub)), 6, 6);
        check("add_sub_cancel", n_add + n_sub - a0, 0);
        c0 = n_clr;
        press(7'((1 << BClr) | (1 << BStart)), 6, 6);
        check("clear_pulse", n_clr - c0, 1);
        check("clear_state", state, 0);
        repeat (3) press(7'(1 << BDn), 6, 6);
        check("speed_l0", speed_lvl, 0);

        // Enter RUN, then pause exactly when the prescaler holds 10.
        pins = 7'(1 << BStart);
        k = 0;
        while (m_state != 1 && k < 20) begin
            step(1);
            k++;
        end
        check("run_entry", state, 1);
        pins = '0;
        step(5);
        pins = 7'(1 << BStart);
        step(6);
        pins = '0;
        step(100);
        check("paused_hold", state, 2);
        press(7'(1 << BStart), 6, 6);
        step(4);
        check("resume_first_tick", first_gap, 6);
        rst = 1'b1;
        step(1);
        check("reset_state", state, 0);
        check("reset_run", run, 0);
        rst = 1'b0;
        step(3);

        repeat (250) begin
            if ($urandom_range(0, 30) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            al = ($urandom_range(0, 4) == 0);
            b = int'($urandom_range(0, 6));
            press(7'(1 << b), int'($urandom_range(1, 8)), int'($urandom_range(3, 10)));
        end
        al = 1'b0;
        step(4);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
